// File: rtl/machina_pkg.sv
// Shared widths, value types and saturation helper for the machina learning fabric.
package machina_pkg;

    localparam int ARG_WIDTH    = 8;
    localparam int RES_WIDTH    = 16;
    localparam int ERR_WIDTH    = 16;
    localparam int FBK_WIDTH    = 16;
    localparam int WEIGHT_WIDTH = 16;
    // Forward accumulator: 16-bit partial sums plus headroom for bias and several inputs.
    localparam int ACC_WIDTH    = 20;

    typedef logic        [ARG_WIDTH-1:0]    arg_t;
    typedef logic signed [RES_WIDTH-1:0]    res_t;
    typedef logic signed [ERR_WIDTH-1:0]    err_t;
    typedef logic signed [FBK_WIDTH-1:0]    fbk_t;
    typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        RES,
        BWD,
        FBK
    } state_t;

    localparam logic signed [31:0] SAT_MAX = 32'sd32767;
    localparam logic signed [31:0] SAT_MIN = -32'sd32768;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > SAT_MAX) begin
            return 16'sh7fff;
        end else if (x < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/associate_mac.sv
// Signed multiply, arithmetic right shift and add; optionally saturates the sum to 16 bits.
module associate_mac
    import machina_pkg::*;
#(
    parameter int SHIFT = 8
)
(
    input  logic signed [15:0]          mul_a,
    input  logic signed [15:0]          mul_b,
    input  logic signed [ACC_WIDTH-1:0] addend,
    input  logic                        sat_en,
    output logic signed [ACC_WIDTH-1:0] sum
);

    logic signed [31:0] prod;
    logic signed [31:0] wide;

    // A 32-bit product covers both the 16x8 forward and the 16x16 feedback cases.
    assign prod = 32'(mul_a) * 32'(mul_b);
    assign wide = 32'(addend) + (prod >>> SHIFT);

    // Saturated result is sign-extended back so callers see a single accumulator-wide bus.
    always_comb sum = sat_en ? ACC_WIDTH'(sat16(wide)) : wide[ACC_WIDTH-1:0];

endmodule

// File: rtl/associate.sv
// Trainable linear neuron: forward weighted sum plus bias, backward feedback and delta-rule update.
module associate
    import machina_pkg::*;
#(
    parameter int ARGN = 2,
    parameter int RATE = 1
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          arg_valid,
    input  logic [ARGN*ARG_WIDTH-1:0]     arg_data,
    output logic                          arg_ready,
    output logic                          res_valid,
    output logic signed [RES_WIDTH-1:0]   res_data,
    input  logic                          res_ready,
    input  logic                          err_valid,
    input  logic signed [ERR_WIDTH-1:0]   err_data,
    output logic                          err_ready,
    output logic                          fbk_valid,
    output logic [ARGN*FBK_WIDTH-1:0]     fbk_data,
    input  logic                          fbk_ready
);

    localparam int IDX_W = (ARGN > 1) ? $clog2(ARGN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARGN - 1);

    state_t                      state_reg, state_next;
    logic [IDX_W-1:0]            idx_reg;
    arg_t                        args_reg [ARGN];
    logic signed [ACC_WIDTH-1:0] acc_reg;
    err_t                        err_reg;
    res_t                        res_reg;
    fbk_t                        fbk_reg [ARGN];
    weight_t                     weights [ARGN];
    weight_t                     bias;

    logic                        idx_last, arg_fire, err_fire, in_bwd;
    arg_t                        arg_cur;
    weight_t                     w_cur, w_upd, bias_upd;
    logic signed [15:0]          mx_b, arg_ext;
    logic signed [ACC_WIDTH-1:0] mx_addend, mx_sum, mu_sum;
    res_t                        res_sat;
    fbk_t                        fbk_cur;

    assign idx_last = (idx_reg == IDX_LAST);
    assign arg_fire = arg_valid & arg_ready;
    assign err_fire = err_valid & err_ready;
    assign in_bwd   = (state_reg == BWD);
    assign arg_cur  = args_reg[idx_reg];
    assign w_cur    = weights[idx_reg];
    assign arg_ext  = $signed({8'h00, arg_cur});

    // Shared w_i * x product: x is the activation in FWD and the error in BWD.
    assign mx_b      = in_bwd ? err_reg : arg_ext;
    assign mx_addend = (state_reg == FWD) ? acc_reg : '0;

    associate_mac #(.SHIFT(8)) u_mac_w (
        .mul_a  (w_cur),
        .mul_b  (mx_b),
        .addend (mx_addend),
        .sat_en (in_bwd),
        .sum    (mx_sum)
    );

    // Delta-rule step err * a_i scaled by 2^-(8+RATE), added onto the current weight.
    associate_mac #(.SHIFT(8 + RATE)) u_mac_upd (
        .mul_a  (err_reg),
        .mul_b  (arg_ext),
        .addend (ACC_WIDTH'(w_cur)),
        .sat_en (1'b0),
        .sum    (mu_sum)
    );

    assign res_sat  = sat16(32'(mx_sum));
    assign fbk_cur  = sat16(32'(mx_sum));
    assign w_upd    = sat16(32'(mu_sum));
    assign bias_upd = sat16(32'(bias) + 32'(err_reg >>> RATE));

    // State register; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs; a pending error wins over a pending argument.
    always_comb begin
        state_next = state_reg;
        arg_ready  = 1'b0;
        err_ready  = 1'b0;
        res_valid  = 1'b0;
        fbk_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                err_ready = rst_n;
                arg_ready = rst_n & ~err_valid;
                if (err_valid) begin
                    state_next = BWD;
                end else if (arg_valid) begin
                    state_next = FWD;
                end
            end
            FWD: begin
                if (idx_last) state_next = RES;
            end
            RES: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            BWD: begin
                if (idx_last) state_next = FBK;
            end
            FBK: begin
                fbk_valid = 1'b1;
                if (fbk_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, step the accumulator and feedback one input per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg <= '0;
            acc_reg <= '0;
            err_reg <= '0;
            res_reg <= '0;
            bias    <= '0;
            for (int i = 0; i < ARGN; i++) begin
                args_reg[i] <= '0;
                fbk_reg[i]  <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_reg <= '0;
                    if (err_fire) begin
                        err_reg <= err_data;
                    end else if (arg_fire) begin
                        for (int i = 0; i < ARGN; i++) begin
                            args_reg[i] <= arg_data[i*ARG_WIDTH +: ARG_WIDTH];
                        end
                        acc_reg <= ACC_WIDTH'(bias);
                    end
                end
                FWD: begin
                    acc_reg <= mx_sum;
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_last) res_reg <= res_sat;
                end
                BWD: begin
                    for (int i = 0; i < ARGN; i++) begin
                        if (idx_reg == IDX_W'(i)) fbk_reg[i] <= fbk_cur;
                    end
                    if (en && idx_last) bias <= bias_upd;
                    idx_reg <= idx_reg + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Weights keep their value through reset; feedback above used the pre-update weight.
    always_ff @(posedge clk) begin
        if (rst_n && en && in_bwd) begin
            for (int i = 0; i < ARGN; i++) begin
                if (idx_reg == IDX_W'(i)) weights[i] <= w_upd;
            end
        end
    end

    assign res_data = res_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ARGN; gi++) begin : g_fbk
            assign fbk_data[gi*FBK_WIDTH +: FBK_WIDTH] = fbk_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_associate.sv
// Scoreboard bench for the associate neuron: model-predicted results queued at issue, checked at output.
module tb_associate;
    import machina_pkg::*;

    localparam int ARGN = 2;
    localparam int RATE = 1;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       en = 1'b0;
    logic                       arg_valid = 1'b0;
    logic [ARGN*8-1:0]          arg_data = '0;
    logic                       arg_ready;
    logic                       res_valid;
    logic signed [15:0]         res_data;
    logic                       res_ready = 1'b0;
    logic                       err_valid = 1'b0;
    logic signed [15:0]         err_data = '0;
    logic                       err_ready;
    logic                       fbk_valid;
    logic [ARGN*16-1:0]         fbk_data;
    logic                       fbk_ready = 1'b0;

    always #5 clk = ~clk;

    associate #(.ARGN(ARGN), .RATE(RATE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .arg_valid (arg_valid),
        .arg_data  (arg_data),
        .arg_ready (arg_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .err_valid (err_valid),
        .err_data  (err_data),
        .err_ready (err_ready),
        .fbk_valid (fbk_valid),
        .fbk_data  (fbk_data),
        .fbk_ready (fbk_ready)
    );

    int                 n_checks = 0;
    int                 n_pass = 0;
    int                 m_w [ARGN];
    int                 m_bias = 0;
    logic [ARGN*8-1:0]  m_arg = '0;
    int                 res_q [$];
    logic [ARGN*16-1:0] fbk_q [$];
    logic [15:0]        pats [4] = '{16'h0000, 16'h00ff, 16'hff00, 16'hffff};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int m_sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int model_fwd(input logic [ARGN*8-1:0] a);
        logic signed [19:0] acc;
        acc = 20'(m_bias);
        for (int i = 0; i < ARGN; i++) begin
            acc = acc + 20'((m_w[i] * int'(a[i*8 +: 8])) >>> 8);
        end
        return m_sat(int'(acc));
    endfunction

    task automatic model_bwd(input int e, output logic [ARGN*16-1:0] f);
        int nw [ARGN];
        for (int i = 0; i < ARGN; i++) begin
            f[i*16 +: 16] = 16'(m_sat((e * m_w[i]) >>> 8));
            nw[i] = m_sat(m_w[i] + ((e * int'(m_arg[i*8 +: 8])) >>> (8 + RATE)));
        end
        if (en) begin
            for (int i = 0; i < ARGN; i++) m_w[i] = nw[i];
            m_bias = m_sat(m_bias + (e >>> RATE));
        end
    endtask

    task automatic set_weights(input int w0, input int w1);
        @(negedge clk);
        dut.weights[0] = 16'(w0);
        dut.weights[1] = 16'(w1);
        m_w[0] = w0;
        m_w[1] = w1;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < ARGN; i++) check({tag, "_w"}, int'(dut.weights[i]), m_w[i]);
        check({tag, "_bias"}, int'(dut.bias), m_bias);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        arg_valid = 1'b0;
        err_valid = 1'b0;
        res_ready = 1'b0;
        fbk_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_arg_ready", arg_ready, 0);
        check("rst_err_ready", err_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_fbk_valid", fbk_valid, 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_fbk_data", fbk_data, 0);
        check("rst_bias", int'(dut.bias), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_bias = 0;
        m_arg = '0;
        res_q.delete();
        fbk_q.delete();
    endtask

    // Push expectation, present the argument and return just after the accepting edge.
    task automatic fwd_send(input logic [ARGN*8-1:0] a);
        int n;
        res_q.push_back(model_fwd(a));
        m_arg = a;
        @(negedge clk);
        arg_data = a;
        arg_valid = 1'b1;
        #1;
        n = 0;
        while (!arg_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n == 50) check("arg_accept", 0, 1);
        @(posedge clk); #1;
        arg_valid = 1'b0;
    endtask

    task automatic fwd_collect(input int hold, output int r);
        int lat;
        res_t first;
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("fwd_latency", lat, ARGN);
        first = res_data;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", int'(res_data), int'(first));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_clear", res_valid, 0);
        r = int'(first);
        if (res_q.size() == 0) check("res_q_empty", 1, 0);
        else check("res_data", r, res_q.pop_front());
        $display("fwd arg=%h res=%h", m_arg, first);
    endtask

    task automatic err_send(input int e);
        logic [ARGN*16-1:0] f;
        int n;
        model_bwd(e, f);
        fbk_q.push_back(f);
        @(negedge clk);
        err_data = 16'(e);
        err_valid = 1'b1;
        #1;
        n = 0;
        while (!err_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n == 50) check("err_accept", 0, 1);
        @(posedge clk); #1;
        err_valid = 1'b0;
    endtask

    task automatic bwd_collect(output logic [ARGN*16-1:0] f);
        int lat;
        lat = 0;
        while (!fbk_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bwd_latency", lat, ARGN);
        f = fbk_data;
        fbk_ready = 1'b1;
        @(posedge clk); #1;
        fbk_ready = 1'b0;
        check("fbk_valid_clear", fbk_valid, 0);
        if (fbk_q.size() == 0) check("fbk_q_empty", 1, 0);
        else check("fbk_data", f, fbk_q.pop_front());
        $display("bwd err=%h fbk=%h en=%0d", err_data, f, en);
    endtask

    task automatic do_fwd(input logic [ARGN*8-1:0] a, input int hold, output int r);
        fwd_send(a);
        fwd_collect(hold, r);
    endtask

    task automatic do_bwd(input int e, output logic [ARGN*16-1:0] f);
        err_send(e);
        bwd_collect(f);
    endtask

    // Train on the four binary patterns; tmask[s]=1 means target 0x00ff for pattern s.
    task automatic train(input logic [3:0] tmask, input string name);
        int r, act, e;
        logic [ARGN*16-1:0] f;
        do_reset();
        set_weights(0, 0);
        en = 1'b1;
        for (int ep = 0; ep < 25; ep++) begin
            for (int s = 0; s < 4; s++) begin
                do_fwd(pats[s], 0, r);
                act = (r < 0) ? 0 : 255;
                e = (tmask[s] ? 255 : 0) - act;
                do_bwd(e, f);
            end
        end
        check_state(name);
        en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            do_fwd(pats[s], 0, r);
            act = (r < 0) ? 0 : 255;
            e = (tmask[s] ? 255 : 0) - act;
            check({name, "_err"}, e, 0);
        end
    endtask

    initial begin
        int r;
        logic [ARGN*16-1:0] f;

        do_reset();

        // Forward of an all-zero argument with random small weights and zero bias.
        set_weights(int'($urandom_range(30)) - 15, int'($urandom_range(30)) - 15);
        do_fwd(16'h0000, 0, r);
        check("fwd_zero", r, 0);

        // Zero error leaves the state untouched even with learning on.
        en = 1'b1;
        do_fwd(16'h0000, 0, r);
        do_bwd(0, f);
        check("bwd_zero_fbk", f, 32'h0);
        check_state("bwd_zero");

        train(4'b1000, "and");
        train(4'b1110, "or");

        // Learning disabled: feedback produced, weights and bias frozen.
        do_reset();
        en = 1'b0;
        set_weights(16'h0100, 16'h0100);
        do_fwd(16'hffff, 0, r);
        check("dis_res", r, 32'h01fe);
        do_bwd(16'h0100, f);
        check("dis_fbk", f, 32'h01000100);
        do_fwd(16'hffff, 0, r);
        check("dis_res_again", r, 32'h01fe);
        check_state("dis");

        // Result held under backpressure.
        do_fwd(16'h80ff, 5, r);

        // Simultaneous arg and err in IDLE: err first, arg on the next IDLE cycle.
        en = 1'b1;
        model_bwd(-64, f);
        fbk_q.push_back(f);
        res_q.push_back(model_fwd(16'h40c0));
        m_arg = 16'h40c0;
        @(negedge clk);
        arg_data = 16'h40c0;
        arg_valid = 1'b1;
        err_data = -16'sd64;
        err_valid = 1'b1;
        #1;
        check("pri_err_ready", err_ready, 1);
        check("pri_arg_ready", arg_ready, 0);
        @(posedge clk); #1;
        err_valid = 1'b0;
        check("pri_busy_arg_ready", arg_ready, 0);
        bwd_collect(f);
        check("pri_idle_arg_ready", arg_ready, 1);
        @(posedge clk); #1;
        arg_valid = 1'b0;
        fwd_collect(0, r);
        check_state("pri");

        // Saturation at both ends of the 16-bit range.
        set_weights(32767, 32767);
        do_fwd(16'hffff, 0, r);
        check("sat_pos_res", r, 32767);
        do_bwd(32767, f);
        check("sat_fbk", f, 32'h7fff7fff);
        check_state("sat_pos");
        set_weights(-32768, -32768);
        do_fwd(16'hffff, 0, r);
        check("sat_neg_res", r, -32768);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/associate.md
Name: associate

Overview:
- Single trainable linear neuron (perceptron node) for the machina learning fabric.
- Forward pass: takes an ARGN-element vector of unsigned 8-bit activations and produces a signed 16-bit weighted sum plus bias.
- Backward pass: takes a signed error and returns per-input feedback err*w_i for upstream nodes.
- When learning is enabled, the backward pass also updates the weights and bias (delta rule, step 2^-RATE).

Parameters:
- ARGN, 2, number of inputs (weights).
- RATE, 1, learning-rate right shift applied to every update.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  learning enable; 1 = backward pass updates weights/bias
- arg_valid  in  1  argument vector valid
- arg_data  in  ARGN*8  packed [ARGN-1:0][7:0] unsigned Q0.8 inputs
- arg_ready  out  1  argument accept
- res_valid  out  1  result valid
- res_data  out  16  signed Q8.8 result
- res_ready  in  1  result accept
- err_valid  in  1  error valid
- err_data  in  16  signed error (same scale as res)
- err_ready  out  1  error accept
- fbk_valid  out  1  feedback valid
- fbk_data  out  ARGN*16  packed [ARGN-1:0][15:0] signed feedback
- fbk_ready  in  1  feedback accept

Behaviour:
- Handshakes: a transfer occurs on a clk edge with valid&ready. Outputs hold stable while valid&!ready.
- State: array `weights[ARGN]`, signed 16-bit Q8.8, at that hierarchical name so benches can preload it. `bias`, signed 16-bit.
- `weights` have no reset and power up 0. Reset clears bias, latched args and state only.
- rst_n=0 at an edge: state->IDLE; arg_ready=err_ready=0 during reset; res_valid=fbk_valid=0; res_data=0; fbk_data=0; bias=0.
- Reset mid-operation aborts the operation; partial results are discarded.
- FSM: IDLE, FWD, RES, BWD, FBK.
- IDLE: arg_ready=1 and err_ready=1. If err and arg are both valid, err is accepted first and arg_ready is deasserted that cycle.
- IDLE, arg accepted: latch arg_data, acc=bias, go to FWD.
- FWD: one input per cycle, acc += (w_i * a_i) >>> 8. Products are 24-bit signed; the accumulator is 20-bit. After ARGN cycles saturate to 16 bits, drive res_data, go to RES.
- RES: res_valid=1 until res_ready, then IDLE.
- Forward latency: ARGN cycles from accept to res_valid.
- IDLE, err accepted: latch err, go to BWD.
- BWD: one input per cycle, i = 0..ARGN-1.
  - fbk_i = sat16((err * w_i) >>> 8), using the pre-update weight.
  - If en=1: w_i = sat16(w_i + ((err * a_i) >>> (8+RATE))), where a_i is the last latched arg.
  - If en=1: bias = sat16(bias + (err >>> RATE)), applied once on the last BWD cycle.
  - If en=0: weights and bias are unchanged; feedback is still produced.
- After ARGN BWD cycles go to FBK.
- FBK: fbk_valid=1 until fbk_ready, then IDLE.
- A backward pass with no prior forward since reset uses arg=0, so only the bias changes.
- Forward-only passes are legal; repeated forwards without backward are allowed.
- All shifts are arithmetic; saturation clamps to [-32768, 32767].

Decomposition:
- Package machina_pkg:
  - ARG_WIDTH=8, RES_WIDTH=16, ERR_WIDTH=16, FBK_WIDTH=16, WEIGHT_WIDTH=16.
  - Typedefs arg_t, res_t, err_t, fbk_t, weight_t.
  - Saturate function.
- One sub-module: associate_mac, a signed 16x8/16x16 multiply with shift and saturating add, shared between the FWD and BWD phases.

Test Plan:
- Forward zero after power-up: preload weights with random values in -15..15, bias=0; forward arg=16'h0000 -> res_data=0 after ARGN cycles.
- Backward zero: en=1, forward 16'h0000 -> res=0; backward err=0 -> fbk_data=32'h0, weights/bias unchanged.
- AND training:
  - Reset, then 25 epochs at en=1 over args {0000, 00ff, ff00, ffff} with targets {0, 0, 0, 00ff}.
  - Activation: act = (res<0) ? 0 : 00ff; err = tgt - act.
  - Then en=0: every arg gives err=0.
- OR training: reset, same procedure with targets {0, 00ff, 00ff, 00ff} -> all errors 0 after training.
- Learning disabled: en=0, weights={0x0100, 0x0100}, arg=ffff -> res=0x01fe. Backward err=0x0100 -> fbk={0x0100, 0x0100}; forward again still returns 0x01fe.
- Backpressure/priority:
  - Hold res_ready=0 for 5 cycles -> res_valid and res_data stable.
  - In IDLE assert arg_valid and err_valid together -> err accepted first, arg on the following IDLE cycle.
